instr_fetch_reader: RTL
=======================

// Module: instr_fetch_reader
// PURPOSE
// - Read side of the key-driven instruction memory (the loader writes DIP words at an incrementing address).
// - On each debounced step-key press, fetches one word at the program counter.
// - Latches the word into the instruction register, then advances the PC.
// - Sits between the board keys, the synchronous-read instruction BRAM port, and the LED/seven-seg display.
// PARAMETERS
// - ADDR_W        8      instruction memory address width (PC width)
// - DATA_W        16     instruction word width (IR width)
// - RD_LAT        1      BRAM read latency in clk cycles (>=1)
// - DEBOUNCE_CYC  50000  consecutive stable cycles required to accept a key level (>=2)
// PORTS
// - clk        in   1       system clock; all logic on posedge
// - rst_n      in   1       asynchronous reset, active low
// - step_key   in   1       raw push-button, async, active high: fetch next instruction
// - clr_key    in   1       raw push-button, async, active high: clear PC/IR
// - mem_en     out  1       read enable to BRAM, one-cycle pulse per fetch
// - mem_addr   out  ADDR_W  read address to BRAM; always equals pc
// - mem_rdata  in   DATA_W  BRAM read data, valid RD_LAT cycles after the mem_en cycle
// - pc         out  ADDR_W  program counter (address of the next fetch)
// - ir         out  DATA_W  instruction register (last fetched word)
// - ir_valid   out  1       high once ir holds a fetched word since the last clear/reset
// - busy       out  1       high while a fetch is in flight (state != IDLE)
// BEHAVIOUR
// - Reset (rst_n=0, async): all outputs 0; state=IDLE; sync/debounce flops 0 (key released).
// - Key path, each key independently:
//   - 2-FF synchroniser, then debouncer.
//   - Debouncer accepts the new level only after it has held DEBOUNCE_CYC consecutive cycles.
//   - Any change before then restarts the count.
//   - A rising edge of the accepted level produces a one-cycle pulse (step_p / clr_p).
//   - Holding the key generates exactly one pulse; the release generates none.
// - FSM states: IDLE, REQ, WAIT, CAPT.
//   - IDLE: step_p -> REQ.
//   - REQ: mem_en=1 for exactly this cycle, mem_addr=pc; -> WAIT, wait counter=RD_LAT-1.
//   - WAIT: decrement counter; at 0 -> CAPT. With RD_LAT=1, WAIT lasts 1 cycle at counter 0.
//   - CAPT: ir<=mem_rdata, ir_valid<=1, pc<=pc+1; -> IDLE.
// - Timing and flags:
//   - Latency: step_p in cycle T -> mem_en in T+1 -> ir/pc update visible in cycle T+2+RD_LAT.
//   - busy=1 in REQ/WAIT/CAPT.
// - Arithmetic: pc increments modulo 2^ADDR_W (pc=all-ones -> fetch that address -> pc=0). No carry out.
// - step_p while busy: dropped, not queued.
// - clr_p in any state:
//   - pc<=0, ir<=0, ir_valid<=0, state<=IDLE.
//   - An in-flight fetch is aborted: no ir/pc update afterwards.
//   - clr_p beats step_p in the same cycle; that step is dropped.
// - mem_en never asserts outside REQ.
// - ir holds its value between fetches.
// TESTING (DEBOUNCE_CYC=4, RD_LAT=1 unless noted; BRAM model with programmable latency)
// - Reset: pulse rst_n low mid-cycle -> immediately pc=0, ir=0, ir_valid=0, busy=0, mem_en=0.
// - Single step: mem[0]=16'hA5C3, step_key held 20 cycles ->
//   - exactly one mem_en pulse with mem_addr=0;
//   - then ir=16'hA5C3, pc=1, ir_valid=1, busy=0;
//   - release -> no further fetch.
// - Bounce: step_key toggled every 2 cycles for 30 cycles, then low -> no mem_en, pc=0.
// - Busy drop (RD_LAT=3): second step_p issued during WAIT -> only one mem_en; pc advances by 1.
// - Wrap: preload pc=8'hFF via 255 steps, mem[8'hFF]=16'h1234, step ->
//   - mem_addr=8'hFF, ir=16'h1234, pc=8'h00.
// - Clear (RD_LAT=3): clr_p during WAIT -> pc=0, ir=0, ir_valid=0, no capture.
// - Clear priority: clr_p and step_p in the same cycle -> clear only, no mem_en.

Source files
------------

// File: rtl/instr_fetch_reader_if.sv
// Read port of the synchronous instruction BRAM.
// The fetcher (master) drives enable and address; the BRAM (slave) returns data.
interface instr_fetch_reader_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
);
  logic              mem_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata;

  modport master (output mem_en, output mem_addr, input  mem_rdata);
  modport slave  (input  mem_en, input  mem_addr, output mem_rdata);
endinterface

// File: rtl/instr_fetch_reader.sv
// Key-driven instruction fetcher.
// Each debounced press of the step key reads one word at the PC from the
// instruction BRAM, latches it into the IR and advances the PC. The clear
// key resets PC/IR and aborts any fetch in flight.
module instr_fetch_reader #(
  parameter int ADDR_W       = 8,
  parameter int DATA_W       = 16,
  parameter int RD_LAT       = 1,
  parameter int DEBOUNCE_CYC = 50000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_step_key,
  input  logic                i_clr_key,
  instr_fetch_reader_if.master mem,
  output logic [ADDR_W-1:0]   o_pc,
  output logic [DATA_W-1:0]   o_ir,
  output logic                o_ir_valid,
  output logic                o_busy
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYC);
  localparam int LAT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(RD_LAT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_CAPT
  } state_t;

  // Key index 0 = step, 1 = clear; both keys share one debounce structure.
  logic [1:0]       w_key_raw;
  logic [1:0]       r_sync1;
  logic [1:0]       r_sync2;
  logic [1:0]       r_level;
  logic [1:0]       r_pulse;
  logic [CNT_W-1:0] r_cnt [2];
  logic             w_step_p;
  logic             w_clr_p;

  state_t            r_state;
  logic [LAT_W-1:0]  r_wait;
  logic              r_mem_en;
  logic [ADDR_W-1:0] r_pc;
  logic [DATA_W-1:0] r_ir;
  logic              r_ir_valid;
  logic              r_busy;

  assign w_key_raw = {i_clr_key, i_step_key};
  assign w_step_p  = r_pulse[0];
  assign w_clr_p   = r_pulse[1];

  // Synchronise each key, accept a level once it has held DEBOUNCE_CYC cycles,
  // and emit a one-cycle pulse when the accepted level rises.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_level <= '0;
      r_pulse <= '0;
      // NOTE: r_cnt is a two-entry register array, not a RAM, so it is reset
      // like any other flop; a real memory would be left unreset.
      for (int k = 0; k < 2; k++) r_cnt[k] <= '0;
    end else begin
      // NOTE: every flop here uses <= so all of them sample the pre-edge
      // values; r_sync2 must see the old r_sync1, not the one just written.
      r_sync1 <= w_key_raw;
      r_sync2 <= r_sync1;
      for (int k = 0; k < 2; k++) begin
        r_pulse[k] <= 1'b0;
        if (r_sync2[k] != r_level[k]) begin
          if (r_cnt[k] == CNT_LAST) begin
            r_level[k] <= r_sync2[k];
            r_pulse[k] <= r_sync2[k];
            r_cnt[k]   <= '0;
          end else begin
            r_cnt[k] <= r_cnt[k] + 1'b1;
          end
        end else begin
          r_cnt[k] <= '0;
        end
      end
    end
  end

  // Fetch FSM with registered outputs; clear overrides everything, including
  // a step pulse arriving in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_wait     <= '0;
      r_mem_en   <= 1'b0;
      r_pc       <= '0;
      r_ir       <= '0;
      r_ir_valid <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_mem_en <= 1'b0;
      if (w_clr_p) begin
        r_state    <= S_IDLE;
        r_pc       <= '0;
        r_ir       <= '0;
        r_ir_valid <= 1'b0;
        r_busy     <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (w_step_p) begin
              r_state  <= S_REQ;
              r_mem_en <= 1'b1;
              r_busy   <= 1'b1;
            end
          end
          S_REQ: begin
            r_state <= S_WAIT;
            r_wait  <= LAT_LAST;
          end
          S_WAIT: begin
            // The read word is valid during the last WAIT cycle; loading it on
            // the edge into CAPT makes the new IR/PC visible during CAPT.
            if (r_wait == '0) begin
              r_state    <= S_CAPT;
              r_ir       <= mem.mem_rdata;
              r_ir_valid <= 1'b1;
              r_pc       <= r_pc + 1'b1;
            end else begin
              r_wait <= r_wait - 1'b1;
            end
          end
          S_CAPT: begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
          default: begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign mem.mem_en   = r_mem_en;
  assign mem.mem_addr = r_pc;
  assign o_pc         = r_pc;
  assign o_ir         = r_ir;
  assign o_ir_valid   = r_ir_valid;
  assign o_busy       = r_busy;

endmodule
